// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// the response flag struct, and access-size / legality / byte-enable helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef struct packed {
    logic misalign;
    logic illegal;
  } dmem_flags_t;

  // Access size in bytes; funct3[1:0] encodes log2(size) for every legal op.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] funct3, input logic write, input int dw);
    if (write) begin
      case (funct3)
        F3_B, F3_H, F3_W: return 1'b1;
        F3_D:             return (dw == 64);
        default:          return 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
        F3_D, F3_WU:                    return (dw == 64);
        default:                        return 1'b0;
      endcase
    end
  endfunction

  // Low address bits not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] lo);
    logic [3:0] m;
    m = size_bytes(funct3) - 4'd1;
    return |({1'b0, lo} & m);
  endfunction

  // size ones shifted up to the byte offset; lanes above a 32-bit word are cleared.
  function automatic logic [7:0] be_gen(input logic [2:0] funct3, input logic [2:0] offset,
                                        input int dw);
    logic [7:0] ones;
    logic [7:0] be;
    case (funct3[1:0])
      2'b00:   ones = 8'h01;
      2'b01:   ones = 8'h03;
      2'b10:   ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    be = ones << offset;
    if (dw == 32) be[7:4] = 4'h0;
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to funct3.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           word,
  input  logic [2:0]                      funct3,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  output logic [DATA_WIDTH-1:0]           data
);

  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] up;
  logic [6:0]            nbits;
  logic [6:0]            amt;

  // Extend by parking the field at the top and shifting it back down
  // (arithmetic for signed loads), which avoids width-dependent replications.
  always_comb begin
    sh = word >> {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   nbits = 7'd8;
      2'b01:   nbits = 7'd16;
      2'b10:   nbits = 7'd32;
      default: nbits = 7'(DATA_WIDTH);
    endcase
    amt = 7'(DATA_WIDTH) - nbits;
    up  = sh << amt;
    if (!funct3[2]) data = DATA_WIDTH'($signed(up) >>> amt);
    else            data = up >> amt;
  end

endmodule

// File: rtl/data_memory_lsu.sv
// MEM-stage data memory with byte-lane loads/stores, error flagging and a
// READ_LATENCY-deep response pipe that stalls as a whole under backpressure.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 12,
  parameter int    DATA_WIDTH   = 32,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misalign,
  output logic                  rsp_illegal
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - OFFW);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("data_memory_lsu: DATA_WIDTH must be 32 or 64");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
    $error("data_memory_lsu: READ_LATENCY must be 1..3");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-OFFW-1:0] idx;
  logic [OFFW-1:0]            offset;
  logic [2:0]                 off3;
  logic                       fire, hold;
  logic                       illegal, misalign, be_spill, err;
  logic [7:0]                 be_full;
  logic [NB-1:0]              be;
  logic [DATA_WIDTH-1:0]      wsh, rword, ld_data, s1_data;
  dmem_flags_t                flg_in;

  logic [READ_LATENCY:1] vld_pipe;
  logic [DATA_WIDTH-1:0] dat_pipe [1:READ_LATENCY];
  dmem_flags_t           flg_pipe [1:READ_LATENCY];

  assign hold      = vld_pipe[READ_LATENCY] & ~rsp_ready;
  assign req_ready = ~hold;
  assign fire      = req_valid & req_ready;

  assign idx    = req_addr[ADDR_WIDTH-1:OFFW];
  assign offset = req_addr[OFFW-1:0];
  assign off3   = 3'(offset);

  // Request decode: error flags (illegal wins), lane mask and shifted store data.
  always_comb begin
    illegal  = ~is_legal(req_funct3, req_write, DATA_WIDTH);
    misalign = ~illegal & is_misaligned(req_funct3, off3);
    be_full  = be_gen(req_funct3, off3, DATA_WIDTH);
    // A mask spilling past the word can only come from a bad access; never write it.
    be_spill = |(be_full >> NB);
    be       = be_full[NB-1:0];
    err      = illegal | misalign | be_spill;
    wsh      = req_wdata << {offset, 3'b000};
    flg_in.illegal  = illegal;
    flg_in.misalign = misalign;
  end

  // Byte-enabled store, committed at the fire edge so a following load sees it.
  always_ff @(posedge clock) begin
    if (fire && req_write && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wsh[b*8 +: 8];
      end
    end
  end

  assign rword = mem[idx];

  dmem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word   (rword),
    .funct3 (req_funct3),
    .offset (offset),
    .data   (ld_data)
  );

  // Stores and faulting accesses return zero data.
  assign s1_data = (fire && !req_write && !err) ? ld_data : '0;

  // Response pipe: shifts one stage per cycle, freezes entirely while the head is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        dat_pipe[s] <= '0;
        flg_pipe[s] <= '0;
      end
    end else if (!hold) begin
      vld_pipe[1] <= fire;
      dat_pipe[1] <= s1_data;
      flg_pipe[1] <= fire ? flg_in : '0;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
        flg_pipe[s] <= flg_pipe[s-1];
      end
    end
  end

  assign rsp_valid    = vld_pipe[READ_LATENCY];
  assign rsp_rdata    = dat_pipe[READ_LATENCY];
  assign rsp_misalign = flg_pipe[READ_LATENCY].misalign;
  assign rsp_illegal  = flg_pipe[READ_LATENCY].illegal;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench: a 32-bit/latency-1 instance and a 64-bit/latency-3 instance driven by
// directed steps; expected responses are queued at fire and checked on output.
module tb_data_memory_lsu;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_mis, a_ill;
  logic [2:0]  a_f3;
  logic [11:0] a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_mis, b_ill;
  logic [2:0]  b_f3;
  logic [11:0] b_addr;
  logic [63:0] b_wdata, b_rdata;

  data_memory_lsu #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_FILE("")) u_a (
    .clock(clock), .reset_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rdata),
    .rsp_misalign(a_mis), .rsp_illegal(a_ill));

  data_memory_lsu #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .READ_LATENCY(3), .INIT_FILE("")) u_b (
    .clock(clock), .reset_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rdata),
    .rsp_misalign(b_mis), .rsp_illegal(b_ill));

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  byte unsigned mem_a[int];
  byte unsigned mem_b[int];
  int  cmp_cnt = 0;
  int  err_cnt = 0;
  int  cyc = 0;
  bit  b_held_seen = 0;
  bit  b_hold_prev = 0;
  logic [63:0] b_prev_rdata;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level reference memory; rules written from the ISA description.
  function automatic exp_t model(input bit inst_b, input bit wr, input logic [2:0] f,
                                 input logic [11:0] addr, input logic [63:0] wd);
    exp_t e;
    int dw = inst_b ? 64 : 32;
    int n = 1 << f[1:0];
    logic [63:0] v;
    bit leg;
    if (wr) leg = (f == 3'd0 || f == 3'd1 || f == 3'd2 || (f == 3'd3 && dw == 64));
    else    leg = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5 ||
                   ((f == 3'd3 || f == 3'd6) && dw == 64));
    e.ill = !leg;
    e.mis = leg && ((int'(addr) % n) != 0);
    e.rdata = '0;
    e.cyc = 0;
    if (leg && !e.mis) begin
      if (wr) begin
        for (int i = 0; i < n; i++)
          if (inst_b) mem_b[int'(addr) + i] = wd[8*i +: 8];
          else        mem_a[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = inst_b ? mem_b[int'(addr) + i] : mem_a[int'(addr) + i];
        if (!f[2] && n*8 < dw && v[n*8-1])
          for (int k = n*8; k < dw; k++) v[k] = 1'b1;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic a_op(input bit wr, input logic [2:0] f, input logic [11:0] addr,
                      input logic [31:0] wd);
    exp_t e;
    int n = 0;
    e = model(1'b0, wr, f, addr, {32'b0, wd});
    a_req_valid = 1'b1; a_req_write = wr; a_f3 = f; a_addr = addr; a_wdata = wd;
    @(negedge clock);
    while (!a_req_ready && n < 50) begin n++; @(negedge clock); end
    check("a_req_ready_wait", a_req_ready, 1'b1);
    e.cyc = cyc + 1;
    qa.push_back(e);
    @(posedge clock); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic b_op(input bit wr, input logic [2:0] f, input logic [11:0] addr,
                      input logic [63:0] wd);
    exp_t e;
    int n = 0;
    e = model(1'b1, wr, f, addr, wd);
    b_req_valid = 1'b1; b_req_write = wr; b_f3 = f; b_addr = addr; b_wdata = wd;
    @(negedge clock);
    while (!b_req_ready && n < 50) begin n++; @(negedge clock); end
    check("b_req_ready_wait", b_req_ready, 1'b1);
    e.cyc = cyc + 3;
    qb.push_back(e);
    @(posedge clock); #1;
    b_req_valid = 1'b0;
  endtask

  // Response checker, 32-bit instance.
  always @(negedge clock) begin : mon_a
    exp_t e;
    if (a_rsp_valid === 1'b1 && a_rsp_ready) begin
      check("a_rsp_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_rdata", {32'b0, a_rdata}, e.rdata);
        check("a_misalign", a_mis, e.mis);
        check("a_illegal", a_ill, e.ill);
        check("a_latency", cyc, e.cyc);
      end
    end
  end

  // Response checker, 64-bit instance, plus hold-stability tracking.
  always @(negedge clock) begin : mon_b
    exp_t e;
    if (b_hold_prev && rst_n) begin
      check("b_hold_valid", b_rsp_valid, 1'b1);
      check("b_hold_rdata", b_rdata, b_prev_rdata);
    end
    if (b_rsp_valid === 1'b1 && b_rsp_ready) begin
      check("b_rsp_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_rdata", b_rdata, e.rdata);
        check("b_misalign", b_mis, e.mis);
        check("b_illegal", b_ill, e.ill);
        if (!b_held_seen) check("b_latency", cyc, e.cyc);
      end
    end
    b_hold_prev  = rst_n && b_rsp_valid === 1'b1 && !b_rsp_ready;
    b_prev_rdata = b_rdata;
    if (b_hold_prev) b_held_seen = 1'b1;
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_f3 = 0; a_addr = 0; a_wdata = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_f3 = 0; b_addr = 0; b_wdata = 0; b_rsp_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_a_valid", a_rsp_valid, 1'b0);
    check("rst_a_rdata", {32'b0, a_rdata}, 64'd0);
    check("rst_a_mis", a_mis, 1'b0);
    check("rst_a_ill", a_ill, 1'b0);
    check("rst_a_ready", a_req_ready, 1'b1);
    check("rst_b_valid", b_rsp_valid, 1'b0);
    check("rst_b_ready", b_req_ready, 1'b1);
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;

    // 32-bit, latency 1
    a_op(1, 3'b010, 12'h010, 32'h8000_00F1);  // sw
    a_op(0, 3'b000, 12'h010, 32'h0);          // lb  -> FFFF_FFF1
    a_op(0, 3'b100, 12'h013, 32'h0);          // lbu -> 0000_0080
    a_op(0, 3'b001, 12'h012, 32'h0);          // lh  -> FFFF_8000
    a_op(1, 3'b010, 12'h020, 32'h1122_3344);  // sw
    a_op(1, 3'b000, 12'h021, 32'h0000_00AB);  // sb
    a_op(0, 3'b010, 12'h020, 32'h0);          // lw  -> 1122_AB44
    a_op(1, 3'b001, 12'h022, 32'h0000_1234);  // sh
    a_op(0, 3'b101, 12'h022, 32'h0);          // lhu -> 1234
    a_op(1, 3'b001, 12'h023, 32'h0000_5678);  // sh misaligned, no write
    a_op(0, 3'b010, 12'h006, 32'h0);          // lw misaligned
    a_op(0, 3'b011, 12'h020, 32'h0);          // ld illegal on RV32
    a_op(0, 3'b110, 12'h020, 32'h0);          // lwu illegal on RV32
    a_op(1, 3'b011, 12'h020, 32'hDEAD_BEEF);  // sd illegal, no write
    a_op(1, 3'b100, 12'h020, 32'hDEAD_BEEF);  // store funct3 100 illegal
    a_op(0, 3'b111, 12'h020, 32'h0);          // funct3 111 illegal
    a_op(1, 3'b011, 12'h023, 32'h0);          // illegal beats misaligned
    a_op(0, 3'b010, 12'h020, 32'h0);          // lw -> 1234_AB44, unchanged
    repeat (3) @(posedge clock); #1;

    // 64-bit, latency 3
    b_op(1, 3'b011, 12'h040, 64'h8765_4321_DEAD_BEEF);  // sd
    b_op(0, 3'b110, 12'h044, 64'h0);                    // lwu -> zero-extended upper half
    b_op(0, 3'b010, 12'h044, 64'h0);                    // lw  -> sign-extended
    b_op(0, 3'b011, 12'h040, 64'h0);                    // ld
    b_op(0, 3'b011, 12'h004, 64'h0);                    // ld misaligned
    b_op(1, 3'b010, 12'h04C, 64'hCAFE_F00D);            // sw upper word
    b_op(0, 3'b000, 12'h04F, 64'h0);                    // lb -> ...FFCA
    b_op(0, 3'b101, 12'h04C, 64'h0);                    // lhu -> F00D
    b_op(0, 3'b001, 12'h041, 64'h0);                    // lh misaligned
    b_op(1, 3'b110, 12'h040, 64'h0);                    // store funct3 110 illegal
    for (int i = 0; i < 4; i++)
      b_op(1, 3'b011, 12'(12'h080 + 8*i), 64'h0101_0101_0000_0000 * (i + 1) + 64'(i));
    repeat (5) @(posedge clock); #1;

    // Back-to-back loads with a two-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 4; i++) b_op(0, 3'b011, 12'(12'h080 + 8*i), 64'h0);
      end
      begin
        repeat (3) @(posedge clock); #1;
        b_rsp_ready = 1'b0;
        repeat (2) @(posedge clock); #1;
        b_rsp_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clock); #1;

    // Reset with responses in flight
    b_op(0, 3'b011, 12'h080, 64'h0);
    b_op(0, 3'b011, 12'h088, 64'h0);
    b_op(0, 3'b011, 12'h090, 64'h0);
    check("b_valid_before_rst", b_rsp_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("b_valid_in_rst", b_rsp_valid, 1'b0);
    check("b_rdata_in_rst", b_rdata, 64'd0);
    check("b_ready_in_rst", b_req_ready, 1'b1);
    qb.delete();
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    b_op(0, 3'b011, 12'h088, 64'h0);  // data survives reset
    b_op(0, 3'b000, 12'h04F, 64'h0);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin n++; @(posedge clock); end
    #1;
    check("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
